mac_accumulate_stage: RTL

//   Signed multiply-accumulate core. Sums TermCount products a*b into a wide

---
 rtl/mac_accumulate_stage.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mac_accumulate_stage.sv
// Signed multiply-accumulate over TermCount accepted beats; the wide sum is shifted, narrowed
// and emitted with a one-cycle out_valid strobe. Define MAC_SATURATE_EN for clamping narrowing.
module mac_accumulate_stage #(
    parameter int unsigned DataInputWidth  = 8,
    parameter int unsigned DataOutputWidth = 8,
    parameter int unsigned AccWidth        = 24,
    parameter int unsigned TermCount       = 16,
    parameter int unsigned OutShift        = 0
) (
    input  logic                       clk,
    input  logic                       aclr_n,
    input  logic                       start,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DataInputWidth-1:0]  a,
    input  logic [DataInputWidth-1:0]  b,
    output logic [DataOutputWidth-1:0] DataOut,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overflow
);

    localparam int unsigned ProdWidth = 2 * DataInputWidth;
    localparam int unsigned CntWidth  = (TermCount > 1) ? $clog2(TermCount) : 1;
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(TermCount - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [AccWidth-1:0]         acc_q, acc_d;
    logic [CntWidth-1:0]         count_q, count_d;
    logic [DataOutputWidth-1:0]  data_q, data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        overflow_q, overflow_d;
    logic                        in_ready_q;
    logic                        busy_q;

    logic signed [ProdWidth-1:0]  prod_c;
    logic signed [AccWidth-1:0]   prod_ext_c;
    logic signed [AccWidth-1:0]   shifted_c;
    logic [DataOutputWidth-1:0]   narrow_c;
    logic                         clip_c;

    // Full-precision signed product, sign-extended into the accumulator width
    assign prod_c     = ProdWidth'($signed(a)) * ProdWidth'($signed(b));
    assign prod_ext_c = AccWidth'(prod_c);
    assign shifted_c  = $signed(acc_q) >>> OutShift;

`ifdef MAC_SATURATE_EN
    localparam logic signed [AccWidth-1:0] SatMax =
        AccWidth'((64'd1 << (DataOutputWidth - 1)) - 64'd1);
    localparam logic signed [AccWidth-1:0] SatMin = ~SatMax;

    // Clamp to the signed output range and flag when clamping happened
    always_comb begin
        clip_c   = 1'b0;
        narrow_c = DataOutputWidth'(shifted_c);
        if (shifted_c > SatMax) begin
            clip_c   = 1'b1;
            narrow_c = DataOutputWidth'(SatMax);
        end else if (shifted_c < SatMin) begin
            clip_c   = 1'b1;
            narrow_c = DataOutputWidth'(SatMin);
        end
    end
`else
    assign narrow_c = DataOutputWidth'(shifted_c);
    assign clip_c   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;
        unique case (state_q)
            IDLE: begin
                if (start && !clear) begin
                    acc_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (clear) begin
                    state_d = IDLE;
                end else if (in_valid && in_ready_q) begin
                    acc_d   = acc_q + prod_ext_c;
                    count_d = count_q + CntWidth'(1);
                    if (count_q == LastCount) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!clear) begin
                    data_d      = narrow_c;
                    out_valid_d = 1'b1;
                    overflow_d  = clip_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready and busy are registered from the next state so they line up with state_q
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            data_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= (state_d == ACCUM);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign DataOut   = data_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule
